sdram_protocol_checker: RTL and testbench

// - Passive, parametrised SDRAM bus checker for system benches: sits on the sdram_* pins between the top-level design and the SDRAM model.
// - Decodes each command, tracks per-bank open rows, flags protocol/timing violations (tRCD, tRP, tRAS, tRC, tMRD, refresh interval), counts traffic.
// - Replaces ad-hoc waveform inspection; generalised to any bank count, address and data width, and timing set.

---
 rtl/sdram_check_pkg.sv | 61 ++++++
 rtl/sdram_bank_tracker.sv | 79 +++++++
 rtl/sdram_protocol_checker.sv | 142 ++++++++++++++
 tb/tb_sdram_protocol_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_check_pkg.sv
// Shared types for the SDRAM bus checker: command and error codes, per-bank error bundle, pin decode.
package sdram_check_pkg;

  localparam int unsigned ERR_BITS = 16;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_AREF = 3'd5,
    CMD_MRS  = 3'd6,
    CMD_BST  = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE      = 4'd0,
    ERR_INIT      = 4'd1,
    ERR_MRD       = 4'd2,
    ERR_ACT_OPEN  = 4'd3,
    ERR_RW_IDLE   = 4'd4,
    ERR_TRCD      = 4'd5,
    ERR_TRAS      = 4'd6,
    ERR_TRP       = 4'd7,
    ERR_TRC       = 4'd8,
    ERR_AREF_OPEN = 4'd9,
    ERR_REFI      = 4'd10
  } err_e;

  // Violations a single bank can detect on the current command
  typedef struct packed {
    logic act_open;
    logic rw_idle;
    logic trcd;
    logic tras;
    logic trp;
    logic trc;
  } bank_err_t;

  // Map the control pins to a command; deselected or clock-disabled cycles are NOPs
  function automatic cmd_e decode(input logic cke, input logic csn, input logic rasn,
                                  input logic casn, input logic wen);
    cmd_e c;
    c = CMD_NOP;
    if (cke && !csn) begin
      case ({rasn, casn, wen})
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b010:  c = CMD_PRE;
        3'b001:  c = CMD_AREF;
        3'b000:  c = CMD_MRS;
        3'b110:  c = CMD_BST;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// One bank's view of the bus: open/closed state, open row, ACT and PRE age timers, per-bank checks.
module sdram_bank_tracker
  import sdram_check_pkg::*;
#(
  parameter int unsigned ROW_BITS = 13,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RAS    = 5,
  parameter int unsigned T_RC     = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  cmd_e                cmd,
  input  logic                sel,
  input  logic                a10,
  input  logic [ROW_BITS-1:0] row,
  output logic                active,
  output logic [ROW_BITS-1:0] open_row,
  output bank_err_t           err_c
);

  // Timers saturate at T_RC, which bounds every same-bank constraint
  localparam int unsigned TMR_BITS = $clog2(T_RC + 1);

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;

  bank_state_e         state;
  logic [TMR_BITS-1:0] act_tmr;
  logic [TMR_BITS-1:0] pre_tmr;
  logic                hit_act;
  logic                hit_rw;
  logic                hit_pre;
  logic                hit_aref;
  logic                close_c;

  assign active   = (state == BANK_ACTIVE);
  assign hit_act  = (cmd == CMD_ACT) && sel;
  assign hit_rw   = ((cmd == CMD_RD) || (cmd == CMD_WR)) && sel;
  assign hit_pre  = (cmd == CMD_PRE) && (sel || a10);
  assign hit_aref = (cmd == CMD_AREF);
  // Explicit precharge or auto-precharge closes an open bank
  assign close_c  = active && (hit_pre || (hit_rw && a10));

  // Per-bank violation detection against the current timer values
  always_comb begin
    err_c          = '0;
    err_c.act_open = hit_act && active;
    err_c.rw_idle  = hit_rw && !active;
    err_c.trcd     = hit_rw && active && (act_tmr < TMR_BITS'(T_RCD));
    err_c.tras     = hit_pre && active && (act_tmr < TMR_BITS'(T_RAS));
    err_c.trp      = (hit_act || hit_aref) && (pre_tmr < TMR_BITS'(T_RP));
    err_c.trc      = hit_act && (act_tmr < TMR_BITS'(T_RC));
  end

  // Bank state machine with open row and age timers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BANK_IDLE;
      open_row <= '0;
      act_tmr  <= TMR_BITS'(T_RC);
      pre_tmr  <= TMR_BITS'(T_RC);
    end else begin
      if (hit_act) begin
        state    <= BANK_ACTIVE;
        open_row <= row;
        act_tmr  <= TMR_BITS'(1);
      end else if (act_tmr != TMR_BITS'(T_RC)) begin
        act_tmr <= act_tmr + TMR_BITS'(1);
      end
      if (close_c) begin
        state   <= BANK_IDLE;
        pre_tmr <= TMR_BITS'(1);
      end else if (pre_tmr != TMR_BITS'(T_RC)) begin
        pre_tmr <= pre_tmr + TMR_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_protocol_checker.sv
// Passive SDRAM bus monitor: decodes commands, flags protocol/timing violations, counts traffic.
module sdram_protocol_checker
  import sdram_check_pkg::*;
#(
  parameter int unsigned BANKS    = 4,
  parameter int unsigned ROW_BITS = 13,
  parameter int unsigned DQM_BITS = 2,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RAS    = 5,
  parameter int unsigned T_RC     = 7,
  parameter int unsigned T_MRD    = 2,
  parameter int unsigned T_REFI   = 390,
  parameter int unsigned CNT_BITS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sdram_cke,
  input  logic                     sdram_csn,
  input  logic                     sdram_rasn,
  input  logic                     sdram_casn,
  input  logic                     sdram_wen,
  input  logic [ROW_BITS-1:0]      sdram_a,
  input  logic [$clog2(BANKS)-1:0] sdram_ba,
  input  logic [DQM_BITS-1:0]      sdram_dqm,
  output logic                     err_valid,
  output logic [3:0]               err_code,
  output logic [ERR_BITS-1:0]      err_flags,
  output logic                     initialised,
  output logic [CNT_BITS-1:0]      act_count,
  output logic [CNT_BITS-1:0]      rd_count,
  output logic [CNT_BITS-1:0]      wr_count,
  output logic [CNT_BITS-1:0]      ref_count
);

  localparam int unsigned BA_BITS   = $clog2(BANKS);
  localparam int unsigned MRD_BITS  = $clog2(T_MRD + 1);
  localparam int unsigned REFI_BITS = $clog2(T_REFI + 1);

  cmd_e                 cmd;
  bank_err_t            bank_err [BANKS];
  logic [BANKS-1:0]     bank_active;
  bank_err_t            any_err;
  logic                 any_active;
  logic [ERR_BITS-1:0]  err_now;
  logic [3:0]           code_c;
  logic [MRD_BITS-1:0]  mrd_tmr;
  logic [REFI_BITS-1:0] refi_cnt;
  logic                 refi_fired;
  // Open rows are kept for hierarchical inspection only; mask pins are observed but not checked
  logic [ROW_BITS-1:0]  open_row_unused [BANKS];
  logic                 dqm_unused;

  assign cmd        = decode(sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen);
  assign dqm_unused = ^sdram_dqm;

  // One tracker per bank
  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    sdram_bank_tracker #(
      .ROW_BITS (ROW_BITS),
      .T_RCD    (T_RCD),
      .T_RP     (T_RP),
      .T_RAS    (T_RAS),
      .T_RC     (T_RC)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .cmd      (cmd),
      .sel      (sdram_ba == BA_BITS'(i)),
      .a10      (sdram_a[10]),
      .row      (sdram_a),
      .active   (bank_active[i]),
      .open_row (open_row_unused[i]),
      .err_c    (bank_err[i])
    );
  end

  // Gather bank and global violations, then pick the lowest code
  always_comb begin
    any_err    = '0;
    any_active = 1'b0;
    err_now    = '0;
    code_c     = 4'(ERR_NONE);
    for (int b = 0; b < BANKS; b++) begin
      any_err    = bank_err_t'(any_err | bank_err[b]);
      any_active = any_active | bank_active[b];
    end
    err_now[ERR_INIT]      = !initialised &&
                             (cmd inside {CMD_ACT, CMD_RD, CMD_WR, CMD_BST});
    err_now[ERR_MRD]       = (cmd != CMD_NOP) && (mrd_tmr < MRD_BITS'(T_MRD));
    err_now[ERR_ACT_OPEN]  = any_err.act_open;
    err_now[ERR_RW_IDLE]   = any_err.rw_idle;
    err_now[ERR_TRCD]      = any_err.trcd;
    err_now[ERR_TRAS]      = any_err.tras;
    err_now[ERR_TRP]       = any_err.trp;
    err_now[ERR_TRC]       = any_err.trc;
    err_now[ERR_AREF_OPEN] = (cmd == CMD_AREF) && any_active;
    err_now[ERR_REFI]      = initialised && !refi_fired && (refi_cnt == REFI_BITS'(T_REFI));
    for (int k = ERR_BITS - 1; k > 0; k--) begin
      if (err_now[k]) code_c = 4'(k);
    end
  end

  // Error reporting, init/MRD/refresh tracking and saturating traffic counters
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid   <= 1'b0;
      err_code    <= '0;
      err_flags   <= '0;
      initialised <= 1'b0;
      mrd_tmr     <= MRD_BITS'(T_MRD);
      refi_cnt    <= '0;
      refi_fired  <= 1'b0;
      act_count   <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      ref_count   <= '0;
    end else begin
      err_valid <= |err_now;
      err_code  <= code_c;
      err_flags <= err_flags | err_now;
      if (cmd == CMD_MRS) initialised <= 1'b1;
      if (cmd == CMD_MRS) begin
        mrd_tmr <= MRD_BITS'(1);
      end else if (mrd_tmr != MRD_BITS'(T_MRD)) begin
        mrd_tmr <= mrd_tmr + MRD_BITS'(1);
      end
      if (cmd == CMD_AREF) begin
        refi_cnt   <= '0;
        refi_fired <= 1'b0;
      end else begin
        if (initialised && (refi_cnt != REFI_BITS'(T_REFI))) refi_cnt <= refi_cnt + REFI_BITS'(1);
        if (err_now[ERR_REFI]) refi_fired <= 1'b1;
      end
      if ((cmd == CMD_ACT) && (act_count != '1)) act_count <= act_count + CNT_BITS'(1);
      if ((cmd == CMD_RD) && (rd_count != '1)) rd_count <= rd_count + CNT_BITS'(1);
      if ((cmd == CMD_WR) && (wr_count != '1)) wr_count <= wr_count + CNT_BITS'(1);
      if ((cmd == CMD_AREF) && (ref_count != '1)) ref_count <= ref_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_sdram_protocol_checker.sv
// Directed bench for sdram_protocol_checker: vector table plus reset / REFI / init sequences.
module tb_sdram_protocol_checker;
  import sdram_check_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [1:0]  sdram_dqm;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [15:0] err_flags;
  logic        initialised;
  logic [31:0] act_count, rd_count, wr_count, ref_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    cmd_e       cmd;
    int         ba;
    logic       a10;
    int         mode;   // 0 normal, 1 csn high, 2 cke low
    logic       exp_v;
    logic [3:0] exp_code;
  } vec_t;

  localparam int NVEC = 46;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  sdram_protocol_checker #(
    .BANKS(4), .ROW_BITS(13), .DQM_BITS(2), .T_RCD(2), .T_RP(2), .T_RAS(5),
    .T_RC(7), .T_MRD(2), .T_REFI(390), .CNT_BITS(32)
  ) dut (
    .clk(clk), .reset(reset), .sdram_cke(sdram_cke), .sdram_csn(sdram_csn),
    .sdram_rasn(sdram_rasn), .sdram_casn(sdram_casn), .sdram_wen(sdram_wen),
    .sdram_a(sdram_a), .sdram_ba(sdram_ba), .sdram_dqm(sdram_dqm),
    .err_valid(err_valid), .err_code(err_code), .err_flags(err_flags),
    .initialised(initialised), .act_count(act_count), .rd_count(rd_count),
    .wr_count(wr_count), .ref_count(ref_count)
  );

  function automatic vec_t mk(input cmd_e c, input int ba, input logic a10, input int mode,
                              input logic v, input int code);
    vec_t r;
    r.cmd = c; r.ba = ba; r.a10 = a10; r.mode = mode; r.exp_v = v; r.exp_code = 4'(code);
    return r;
  endfunction

  task automatic drive(input cmd_e c, input int ba, input logic a10, input int mode);
    logic [3:0] p;
    case (c)
      CMD_NOP:  p = 4'b0111;
      CMD_ACT:  p = 4'b0011;
      CMD_RD:   p = 4'b0101;
      CMD_WR:   p = 4'b0100;
      CMD_PRE:  p = 4'b0010;
      CMD_AREF: p = 4'b0001;
      CMD_MRS:  p = 4'b0000;
      default:  p = 4'b0110;
    endcase
    sdram_cke  = (mode != 2);
    sdram_csn  = p[3] | (mode == 1);
    sdram_rasn = p[2];
    sdram_casn = p[1];
    sdram_wen  = p[0];
    sdram_ba   = 2'(ba);
    sdram_a    = 13'(ba * 3 + 1);
    sdram_a[10] = a10;
    sdram_dqm  = 2'(ba);
  endtask

  task automatic cyc(input cmd_e c, input int ba, input logic a10);
    drive(c, ba, a10, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_err(input string name, input logic v, input int code);
    check(name, 32'({err_valid, err_code}), 32'({v, 4'(code)}));
  endtask

  task automatic apply_vec(input int i);
    drive(vecs[i].cmd, vecs[i].ba, vecs[i].a10, vecs[i].mode);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", i), 32'({err_valid, err_code}),
          32'({vecs[i].exp_v, vecs[i].exp_code}));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_err"}, 32'({err_valid, err_code}), 32'd0);
    check({tag, "_flags"}, 32'(err_flags), 32'd0);
    check({tag, "_init"}, 32'(initialised), 32'd0);
    check({tag, "_counts"}, act_count | rd_count | wr_count | ref_count, 32'd0);
  endtask

  initial begin
    int first;
    int pulses;

    vecs[0]  = mk(CMD_MRS,  0, 1'b0, 0, 1'b0, 0);
    vecs[1]  = mk(CMD_ACT,  0, 1'b0, 1, 1'b0, 0);
    vecs[2]  = mk(CMD_ACT,  0, 1'b0, 2, 1'b0, 0);
    vecs[3]  = mk(CMD_ACT,  0, 1'b0, 0, 1'b0, 0);
    vecs[4]  = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[5]  = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[6]  = mk(CMD_RD,   0, 1'b0, 0, 1'b0, 0);
    vecs[7]  = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[8]  = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[9]  = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[10] = mk(CMD_PRE,  0, 1'b0, 0, 1'b0, 0);
    vecs[11] = mk(CMD_ACT,  1, 1'b0, 0, 1'b0, 0);
    vecs[12] = mk(CMD_RD,   1, 1'b0, 0, 1'b1, 5);
    vecs[13] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[14] = mk(CMD_ACT,  2, 1'b0, 0, 1'b0, 0);
    vecs[15] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[16] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[17] = mk(CMD_PRE,  2, 1'b0, 0, 1'b1, 6);
    vecs[18] = mk(CMD_ACT,  2, 1'b0, 0, 1'b1, 7);
    vecs[19] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[20] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[21] = mk(CMD_WR,   2, 1'b0, 0, 1'b0, 0);
    vecs[22] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[23] = mk(CMD_PRE,  0, 1'b1, 0, 1'b0, 0);
    vecs[24] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[25] = mk(CMD_AREF, 0, 1'b0, 0, 1'b0, 0);
    vecs[26] = mk(CMD_RD,   3, 1'b0, 0, 1'b1, 4);
    vecs[27] = mk(CMD_ACT,  3, 1'b0, 0, 1'b0, 0);
    vecs[28] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[29] = mk(CMD_AREF, 0, 1'b0, 0, 1'b1, 9);
    vecs[30] = mk(CMD_ACT,  3, 1'b0, 0, 1'b1, 3);
    vecs[31] = mk(CMD_MRS,  0, 1'b0, 0, 1'b0, 0);
    vecs[32] = mk(CMD_ACT,  0, 1'b0, 0, 1'b1, 2);
    vecs[33] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[34] = mk(CMD_RD,   0, 1'b1, 0, 1'b0, 0);
    vecs[35] = mk(CMD_ACT,  0, 1'b0, 0, 1'b1, 7);
    vecs[36] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[37] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[38] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[39] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[40] = mk(CMD_PRE,  0, 1'b0, 0, 1'b0, 0);
    vecs[41] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[42] = mk(CMD_ACT,  0, 1'b0, 0, 1'b0, 0);
    vecs[43] = mk(CMD_NOP,  0, 1'b0, 0, 1'b0, 0);
    vecs[44] = mk(CMD_WR,   0, 1'b0, 0, 1'b0, 0);
    vecs[45] = mk(CMD_BST,  0, 1'b0, 0, 1'b0, 0);

    // Power-on reset
    reset = 1'b1;
    drive(CMD_NOP, 0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("por");

    // Legal init/ACT/RD/PRE flow with deselect and clock-disable filtering
    for (int i = 0; i <= 10; i++) apply_vec(i);
    check("flow_act", act_count, 32'd1);
    check("flow_rd", rd_count, 32'd1);
    check("flow_init", 32'(initialised), 32'd1);
    check("flow_flags", 32'(err_flags), 32'd0);

    for (int i = 11; i <= 13; i++) apply_vec(i);
    check("trcd_sticky", 32'(err_flags[5]), 32'd1);

    for (int i = 14; i < NVEC; i++) apply_vec(i);
    check("tbl_flags", 32'(err_flags), 32'h03FC);
    check("tbl_act", act_count, 32'd9);
    check("tbl_rd", rd_count, 32'd4);
    check("tbl_wr", wr_count, 32'd2);
    check("tbl_ref", ref_count, 32'd2);

    // Commands before MRS, then double ACT with simultaneous tRC failure
    reset = 1'b1;
    drive(CMD_NOP, 0, 1'b0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("rst1");
    cyc(CMD_ACT, 0, 1'b0);
    check_err("act_pre_init", 1'b1, 1);
    cyc(CMD_MRS, 0, 1'b0);
    check_err("mrs_ok", 1'b0, 0);
    cyc(CMD_NOP, 0, 1'b0);
    cyc(CMD_NOP, 0, 1'b0);
    cyc(CMD_ACT, 0, 1'b0);
    check_err("act_open_prio", 1'b1, 3);
    check("act_open_flags", 32'(err_flags), 32'h010A);

    // Reset with a bank open and flags set; command during reset is ignored
    reset = 1'b1;
    drive(CMD_ACT, 1, 1'b0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("rst2");
    cyc(CMD_RD, 0, 1'b0);
    check_err("rd_after_reset", 1'b1, 1);
    check("rd_after_reset_cnt", rd_count, 32'd1);
    check("rd_after_reset_act", act_count, 32'd0);

    // Refresh interval: single pulse after MRS with no AREF
    cyc(CMD_MRS, 0, 1'b0);
    check_err("refi_mrs", 1'b0, 0);
    first  = -1;
    pulses = 0;
    for (int s = 1; s <= 420; s++) begin
      cyc(CMD_NOP, 0, 1'b0);
      if (err_valid) begin
        pulses++;
        if (first < 0) first = s;
        check("refi_code", 32'(err_code), 32'd10);
      end
    end
    check("refi_first", 32'(first), 32'd391);
    check("refi_pulses", 32'(pulses), 32'd1);
    check("refi_flag", 32'(err_flags[10]), 32'd1);
    cyc(CMD_AREF, 0, 1'b0);
    check_err("refi_aref", 1'b0, 0);
    cyc(CMD_ACT, 3, 1'b0);
    check_err("act_b3", 1'b0, 0);
    cyc(CMD_NOP, 0, 1'b0);
    cyc(CMD_AREF, 0, 1'b0);
    check_err("aref_open", 1'b1, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
